cpu_top: RTL and testbench

CPU_TOP -- requirements
Module: cpu_top

---
 rtl/cpu_top.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_top.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_top.sv
// Single-cycle RV32I core with byte-wide ITCM/DTCM host load ports.
// Define CPU_CSR_EN to add the Zicsr instructions; without it SYSTEM traps.
module cpu_top #(
    parameter int PC_SIZE   = 10,
    parameter int DATA_SIZE = 10,
    parameter int CSR_LEN   = 12
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 start,
    output logic                 error,
    input  logic                 itcm_en,
    input  logic [PC_SIZE-1:0]   itcm_addr,
    input  logic [7:0]           itcm_data,
    input  logic                 dtcm_en,
    input  logic [DATA_SIZE-1:0] dtcm_addr,
    input  logic [7:0]           dtcm_data,
    output logic                 wb_csr_en,
    output logic [CSR_LEN-1:0]   wb_csr_addr,
    output logic [31:0]          wb_csr_data,
    output logic [CSR_LEN-1:0]   exe_csr_addr,
    input  logic [31:0]          csr_exe_data
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [7:0]         itcm [2**PC_SIZE];
    logic [7:0]         dtcm [2**DATA_SIZE];
    logic [31:0]        regs [32];
    logic [PC_SIZE-1:0] pc;
    logic               running;

    logic [31:0] instr, pc32, imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_v, rs2_v, mem_addr, ld_word, wr_data, next_pc;
    logic [31:0] csr_new, csr_src;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  st_be;
    logic        exe, illegal, wr_en, taken, alt, csr_wr;
    logic [DATA_SIZE-1:0] maddr;
    logic        unused_addr;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic sub_sra);
        case (op)
            3'd0:    alu = sub_sra ? a - b : a + b;
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
            3'd3:    alu = {31'b0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = sub_sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (itcm_en) itcm[itcm_addr] <= itcm_data;
    end

    assign instr  = {itcm[pc + PC_SIZE'(3)], itcm[pc + PC_SIZE'(2)],
                     itcm[pc + PC_SIZE'(1)], itcm[pc]};
    assign pc32   = 32'(pc);
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    // Data addresses wrap within the DTCM; word reads wrap byte by byte too.
    assign mem_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign maddr    = mem_addr[DATA_SIZE-1:0];
    assign ld_word  = {dtcm[maddr + DATA_SIZE'(3)], dtcm[maddr + DATA_SIZE'(2)],
                       dtcm[maddr + DATA_SIZE'(1)], dtcm[maddr]};
    assign exe      = !error && (start || running);
    assign unused_addr = ^{mem_addr[31:DATA_SIZE], next_pc[31:PC_SIZE]};

    always_comb begin
        illegal = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        next_pc = pc32 + 32'd4;
        st_be   = 4'b0000;
        taken   = 1'b0;
        alt     = 1'b0;
        csr_wr  = 1'b0;
        csr_new = '0;
        csr_src = '0;
        case (opcode)
            OP_LUI:   begin wr_en = 1'b1; wr_data = imm_u; end
            OP_AUIPC: begin wr_en = 1'b1; wr_data = pc32 + imm_u; end
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_data = pc32 + 32'd4;
                next_pc = pc32 + imm_j;
                illegal = next_pc[1:0] != 2'b00;
            end
            OP_JALR: begin
                wr_en   = 1'b1;
                wr_data = pc32 + 32'd4;
                next_pc = (rs1_v + imm_i) & ~32'd1;
                illegal = (f3 != 3'd0) || next_pc[1];
            end
            OP_BRANCH: begin
                case (f3)
                    3'd0:    taken = rs1_v == rs2_v;
                    3'd1:    taken = rs1_v != rs2_v;
                    3'd4:    taken = $signed(rs1_v) <  $signed(rs2_v);
                    3'd5:    taken = $signed(rs1_v) >= $signed(rs2_v);
                    3'd6:    taken = rs1_v <  rs2_v;
                    3'd7:    taken = rs1_v >= rs2_v;
                    default: illegal = 1'b1;
                endcase
                if (taken) next_pc = pc32 + imm_b;
                if (taken && next_pc[1:0] != 2'b00) illegal = 1'b1;
            end
            OP_LOAD: begin
                wr_en = 1'b1;
                case (f3)
                    3'd0: wr_data = {{24{ld_word[7]}}, ld_word[7:0]};
                    3'd1: begin wr_data = {{16{ld_word[15]}}, ld_word[15:0]}; illegal = mem_addr[0]; end
                    3'd2: begin wr_data = ld_word; illegal = mem_addr[1:0] != 2'b00; end
                    3'd4: wr_data = {24'b0, ld_word[7:0]};
                    3'd5: begin wr_data = {16'b0, ld_word[15:0]}; illegal = mem_addr[0]; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                case (f3)
                    3'd0:    st_be = 4'b0001;
                    3'd1:    begin st_be = 4'b0011; illegal = mem_addr[0]; end
                    3'd2:    begin st_be = 4'b1111; illegal = mem_addr[1:0] != 2'b00; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                wr_en   = 1'b1;
                alt     = (f3 == 3'd5) && f7[5];
                wr_data = alu(rs1_v, imm_i, f3, alt);
                if (f3 == 3'd1) illegal = f7 != 7'b0000000;
                if (f3 == 3'd5) illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OP_OP: begin
                wr_en   = 1'b1;
                wr_data = alu(rs1_v, rs2_v, f3, f7[5]);
                illegal = !((f7 == 7'b0000000) ||
                            (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
            end
`ifdef CPU_CSR_EN
            OP_SYSTEM: begin
                wr_en   = 1'b1;
                wr_data = csr_exe_data;
                csr_src = f3[2] ? {27'b0, rs1} : rs1_v;
                case (f3[1:0])
                    2'b01:   begin csr_new = csr_src; csr_wr = 1'b1; end
                    2'b10:   begin csr_new = csr_exe_data | csr_src;  csr_wr = rs1 != 5'd0; end
                    2'b11:   begin csr_new = csr_exe_data & ~csr_src; csr_wr = rs1 != 5'd0; end
                    default: illegal = 1'b1;
                endcase
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

`ifdef CPU_CSR_EN
    assign exe_csr_addr = (rst_ && opcode == OP_SYSTEM) ? instr[20 +: CSR_LEN] : '0;
    assign wb_csr_en    = rst_ && exe && !illegal && csr_wr;
    assign wb_csr_addr  = wb_csr_en ? instr[20 +: CSR_LEN] : '0;
    assign wb_csr_data  = wb_csr_en ? csr_new : '0;
`else
    logic unused_csr;
    assign unused_csr   = ^{csr_exe_data, csr_new, csr_src, csr_wr};
    assign exe_csr_addr = '0;
    assign wb_csr_en    = 1'b0;
    assign wb_csr_addr  = '0;
    assign wb_csr_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc      <= '0;
            running <= 1'b0;
            error   <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (exe) begin
            running <= 1'b1;
            if (illegal) begin
                error <= 1'b1;
            end else begin
                pc <= next_pc[PC_SIZE-1:0];
                if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
            end
        end
    end

    // Host write is issued last so it overrides a core store to the same byte.
    always_ff @(posedge clk) begin
        if (rst_ && exe && !illegal) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i]) dtcm[maddr + DATA_SIZE'(i)] <= rs2_v[8*i +: 8];
        end
        if (dtcm_en) dtcm[dtcm_addr] <= dtcm_data;
    end
endmodule

// File: tb/tb_cpu_top.sv
// Directed-vector bench for cpu_top: programs are loaded through the host ports.
module tb_cpu_top;
    localparam int PC_SIZE = 10, DATA_SIZE = 10, CSR_LEN = 12;

    logic                 clk, rst_, start, error;
    logic                 itcm_en, dtcm_en, wb_csr_en;
    logic [PC_SIZE-1:0]   itcm_addr;
    logic [DATA_SIZE-1:0] dtcm_addr;
    logic [7:0]           itcm_data, dtcm_data;
    logic [CSR_LEN-1:0]   wb_csr_addr, exe_csr_addr;
    logic [31:0]          wb_csr_data, csr_exe_data;
    int checks = 0, errors = 0;

    cpu_top #(.PC_SIZE(PC_SIZE), .DATA_SIZE(DATA_SIZE), .CSR_LEN(CSR_LEN)) dut (
        .clk(clk), .rst_(rst_), .start(start), .error(error),
        .itcm_en(itcm_en), .itcm_addr(itcm_addr), .itcm_data(itcm_data),
        .dtcm_en(dtcm_en), .dtcm_addr(dtcm_addr), .dtcm_data(dtcm_data),
        .wb_csr_en(wb_csr_en), .wb_csr_addr(wb_csr_addr), .wb_csr_data(wb_csr_data),
        .exe_csr_addr(exe_csr_addr), .csr_exe_data(csr_exe_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic iload(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            itcm_en = 1'b1; itcm_addr = PC_SIZE'(addr + i); itcm_data = w[8*i +: 8];
            tick(1);
        end
        itcm_en = 1'b0;
    endtask

    task automatic dload(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dtcm_en = 1'b1; dtcm_addr = DATA_SIZE'(addr + i); dtcm_data = w[8*i +: 8];
            tick(1);
        end
        dtcm_en = 1'b0;
    endtask

    task automatic hold_reset();
        start = 1'b0;
        rst_  = 1'b0;
        #1;
    endtask

    task automatic go();
        rst_  = 1'b1;
        start = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b1; start = 1'b0; itcm_en = 1'b0; dtcm_en = 1'b0;
        itcm_addr = '0; itcm_data = '0; dtcm_addr = '0; dtcm_data = '0; csr_exe_data = '0;
        #2 rst_ = 1'b0;
        #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (dut.pc !== PC_SIZE'(0)) begin errors++; $display("FAIL reset_pc got %0d want 0", dut.pc); end
        checks++; if (wb_csr_en !== 1'b0 || wb_csr_addr !== '0 || wb_csr_data !== '0 || exe_csr_addr !== '0) begin
            errors++; $display("FAIL reset_csr_out got %b %h %h %h want all 0", wb_csr_en, wb_csr_addr, wb_csr_data, exe_csr_addr);
        end
    endtask

    task automatic test_program();
        logic [31:0] prog [7] = '{32'h00100093, 32'h00402103, 32'h00708183, 32'h0080026F,
                                  32'h0020F233, 32'h0030A3A3, 32'h00000000};
        int          ri [4] = '{1, 2, 3, 4};
        logic [31:0] rv [4] = '{32'd1, 32'd2, 32'd3, 32'd16};
        logic [31:0] w;
        hold_reset();
        for (int i = 0; i < 7; i++) iload(4*i, prog[i]);
        dload(0, 32'd1); dload(4, 32'd2); dload(8, 32'hFFFFFF03);
        go();
        tick(5);
        checks++; if (error !== 1'b0 || dut.pc !== PC_SIZE'(24)) begin
            errors++; $display("FAIL prog_before_trap got err=%b pc=%0d want err=0 pc=24", error, dut.pc);
        end
        tick(1);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(24)) begin
            errors++; $display("FAIL prog_trap got err=%b pc=%0d want err=1 pc=24", error, dut.pc);
        end
        tick(3);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(24)) begin
            errors++; $display("FAIL prog_halted got err=%b pc=%0d want err=1 pc=24", error, dut.pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.regs[ri[i]] !== rv[i]) begin
                errors++; $display("FAIL prog_x%0d got %h want %h", ri[i], dut.regs[ri[i]], rv[i]);
            end
        end
        w = {dut.dtcm[11], dut.dtcm[10], dut.dtcm[9], dut.dtcm[8]};
        checks++; if (w !== 32'd3) begin errors++; $display("FAIL prog_sw got %h want 00000003", w); end
    endtask

    task automatic test_loads();
        hold_reset();
        iload(0, 32'h00900283); iload(4, 32'h00904303); iload(8, 32'h0);
        dload(8, 32'hFFFFFF03);
        go();
        tick(3);
        checks++; if (dut.regs[5] !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_sign got %h want ffffffff", dut.regs[5]); end
        checks++; if (dut.regs[6] !== 32'h000000FF) begin errors++; $display("FAIL lbu_zero got %h want 000000ff", dut.regs[6]); end
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(8)) begin
            errors++; $display("FAIL loads_trap got err=%b pc=%0d want err=1 pc=8", error, dut.pc);
        end
    endtask

    task automatic test_halfword();
        logic [31:0] prog [7] = '{32'h00201083, 32'h00205103, 32'h001006A3, 32'h00201723,
                                  32'h00C02183, 32'h00101203, 32'h00000000};
        int          ri [4] = '{1, 2, 3, 4};
        logic [31:0] rv [4] = '{32'hFFFFA5B6, 32'h0000A5B6, 32'hA5B6B644, 32'h0};
        hold_reset();
        for (int i = 0; i < 7; i++) iload(4*i, prog[i]);
        dload(0, 32'hA5B6C7D8); dload(12, 32'h11223344);
        go();
        tick(5);
        checks++; if (error !== 1'b0 || dut.pc !== PC_SIZE'(20)) begin
            errors++; $display("FAIL half_run got err=%b pc=%0d want err=0 pc=20", error, dut.pc);
        end
        tick(1);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(20)) begin
            errors++; $display("FAIL lh_misalign got err=%b pc=%0d want err=1 pc=20", error, dut.pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.regs[ri[i]] !== rv[i]) begin
                errors++; $display("FAIL half_x%0d got %h want %h", ri[i], dut.regs[ri[i]], rv[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        hold_reset();
        iload(0, 32'h00900313); iload(4, 32'h00202303);
        go();
        tick(1);
        checks++; if (error !== 1'b0 || dut.regs[6] !== 32'd9) begin
            errors++; $display("FAIL mis_pre got err=%b x6=%h want err=0 x6=9", error, dut.regs[6]);
        end
        tick(1);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(4)) begin
            errors++; $display("FAIL lw_misalign got err=%b pc=%0d want err=1 pc=4", error, dut.pc);
        end
        tick(2);
        checks++; if (dut.regs[6] !== 32'd9 || dut.pc !== PC_SIZE'(4)) begin
            errors++; $display("FAIL lw_nowrite got x6=%h pc=%0d want x6=9 pc=4", dut.regs[6], dut.pc);
        end
    endtask

    task automatic test_x0();
        hold_reset();
        iload(0, 32'h00900393); iload(4, 32'h00500013); iload(8, 32'h000003B3); iload(12, 32'h0);
        go();
        tick(2);
        checks++; if (dut.regs[7] !== 32'd9) begin errors++; $display("FAIL x0_pre got %h want 9", dut.regs[7]); end
        checks++; if (dut.regs[0] !== 32'd0) begin errors++; $display("FAIL x0_write got %h want 0", dut.regs[0]); end
        tick(1);
        checks++; if (dut.regs[7] !== 32'd0) begin errors++; $display("FAIL x0_read got %h want 0", dut.regs[7]); end
        tick(1);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(12)) begin
            errors++; $display("FAIL x0_trap got err=%b pc=%0d want err=1 pc=12", error, dut.pc);
        end
    endtask

    task automatic load_alu_prog();
        logic [31:0] prog [19] = '{
            32'hFFB00093, 32'h00300113, 32'h402081B3, 32'h0020A233, 32'h0020B2B3,
            32'h4020D333, 32'h0020D3B3, 32'h00211433, 32'h0020C463, 32'h00100493,
            32'h0020F463, 32'h00200493, 32'h00208463, 32'h12345537, 32'h00001597,
            32'h04400667, 32'h00300493, 32'h00700493, 32'h00000000};
        for (int i = 0; i < 19; i++) iload(4*i, prog[i]);
    endtask

    task automatic test_alu_branch();
        int          ri [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        logic [31:0] rv [12] = '{32'hFFFFFFFB, 32'd3, 32'hFFFFFFF8, 32'd1, 32'd0, 32'hFFFFFFFF,
                                 32'h1FFFFFFF, 32'd24, 32'd7, 32'h12345000, 32'h00001038, 32'd64};
        hold_reset();
        load_alu_prog();
        go();
        tick(15);
        checks++; if (error !== 1'b0 || dut.pc !== PC_SIZE'(72)) begin
            errors++; $display("FAIL alu_flow got err=%b pc=%0d want err=0 pc=72", error, dut.pc);
        end
        tick(1);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL alu_trap got %b want 1", error); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (dut.regs[ri[i]] !== rv[i]) begin
                errors++; $display("FAIL alu_x%0d got %h want %h", ri[i], dut.regs[ri[i]], rv[i]);
            end
        end
    endtask

    task automatic test_host_priority();
        hold_reset();
        iload(0, 32'h05500093); iload(4, 32'h02100023); iload(8, 32'h02100423); iload(12, 32'h0);
        dload(32, 32'h0); dload(40, 32'h0);
        go();
        tick(1);
        dtcm_en = 1'b1; dtcm_addr = DATA_SIZE'(32); dtcm_data = 8'hAA;
        tick(1);
        dtcm_en = 1'b0;
        tick(2);
        checks++; if (dut.dtcm[32] !== 8'hAA) begin errors++; $display("FAIL host_wins got %h want aa", dut.dtcm[32]); end
        checks++; if (dut.dtcm[40] !== 8'h55) begin errors++; $display("FAIL sb_store got %h want 55", dut.dtcm[40]); end
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(12)) begin
            errors++; $display("FAIL host_trap got err=%b pc=%0d want err=1 pc=12", error, dut.pc);
        end
    endtask

    task automatic test_restart();
        hold_reset();
        load_alu_prog();
        go();
        tick(3);
        #3 rst_ = 1'b0;
        #1;
        checks++; if (dut.pc !== PC_SIZE'(0) || error !== 1'b0) begin
            errors++; $display("FAIL midrst_ctl got pc=%0d err=%b want pc=0 err=0", dut.pc, error);
        end
        checks++; if (dut.regs[1] !== 32'd0 || dut.regs[3] !== 32'd0) begin
            errors++; $display("FAIL midrst_regs got x1=%h x3=%h want 0 0", dut.regs[1], dut.regs[3]);
        end
        checks++; if (dut.dtcm[32] !== 8'hAA) begin errors++; $display("FAIL midrst_dtcm got %h want aa", dut.dtcm[32]); end
        start = 1'b0;
        rst_  = 1'b1;
        tick(3);
        checks++; if (dut.pc !== PC_SIZE'(0) || dut.regs[1] !== 32'd0) begin
            errors++; $display("FAIL idle_no_start got pc=%0d x1=%h want pc=0 x1=0", dut.pc, dut.regs[1]);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++; if (dut.pc !== PC_SIZE'(4)) begin errors++; $display("FAIL start_pulse got pc=%0d want 4", dut.pc); end
        tick(15);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(72) || dut.regs[9] !== 32'd7) begin
            errors++; $display("FAIL running_latch got err=%b pc=%0d x9=%h want err=1 pc=72 x9=7", error, dut.pc, dut.regs[9]);
        end
    endtask

    task automatic test_csr();
        hold_reset();
        iload(0, 32'h00100093); iload(4, 32'h30009473); iload(8, 32'h0);
        csr_exe_data = 32'hA5;
        go();
        tick(1);
`ifdef CPU_CSR_EN
        checks++; if (exe_csr_addr !== 12'h300) begin errors++; $display("FAIL csr_raddr got %h want 300", exe_csr_addr); end
        checks++; if (wb_csr_en !== 1'b1 || wb_csr_addr !== 12'h300 || wb_csr_data !== 32'd1) begin
            errors++; $display("FAIL csr_wb got en=%b a=%h d=%h want en=1 a=300 d=1", wb_csr_en, wb_csr_addr, wb_csr_data);
        end
        tick(1);
        checks++; if (dut.regs[8] !== 32'hA5 || wb_csr_en !== 1'b0) begin
            errors++; $display("FAIL csr_rd got x8=%h en=%b want x8=a5 en=0", dut.regs[8], wb_csr_en);
        end
`else
        checks++; if (wb_csr_en !== 1'b0 || exe_csr_addr !== '0 || wb_csr_data !== '0) begin
            errors++; $display("FAIL csr_tied got en=%b ra=%h d=%h want 0", wb_csr_en, exe_csr_addr, wb_csr_data);
        end
        tick(1);
        checks++; if (error !== 1'b1 || dut.pc !== PC_SIZE'(4) || dut.regs[8] !== 32'd0) begin
            errors++; $display("FAIL csr_trap got err=%b pc=%0d x8=%h want err=1 pc=4 x8=0", error, dut.pc, dut.regs[8]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_program();
        test_loads();
        test_halfword();
        test_misaligned();
        test_x0();
        test_alu_branch();
        test_host_priority();
        test_restart();
        test_csr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
